// File: rtl/issue_pair_reg.sv
// Dual-lane issue register that splits a RAW-dependent pair over two cycles and forwards lane-1's result.
// Optional statistics counters are built when ISSUE_PAIR_STATS_EN is defined.
module issue_pair_reg #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    input  logic          ex_stall,
    input  logic [DW-1:0] ex_alu_1,
    input  logic          vld_1_i,
    input  logic [RW-1:0] rs_1_i,
    input  logic [RW-1:0] rt_1_i,
    input  logic [RW-1:0] rd_1_i,
    input  logic          wr_1_i,
    input  logic          use_rs_1_i,
    input  logic          use_rt_1_i,
    input  logic [DW-1:0] data_A_1_i,
    input  logic [DW-1:0] data_B_1_i,
    input  logic [DW-1:0] imm_1_i,
    input  logic [4:0]    shamt_1_i,
    input  logic [1:0]    mux_1_i,
    input  logic [3:0]    fun_1_i,
    input  logic          vld_2_i,
    input  logic [RW-1:0] rs_2_i,
    input  logic [RW-1:0] rt_2_i,
    input  logic [RW-1:0] rd_2_i,
    input  logic          wr_2_i,
    input  logic          use_rs_2_i,
    input  logic          use_rt_2_i,
    input  logic [DW-1:0] data_A_2_i,
    input  logic [DW-1:0] data_B_2_i,
    input  logic [DW-1:0] imm_2_i,
    input  logic [4:0]    shamt_2_i,
    input  logic [1:0]    mux_2_i,
    input  logic [3:0]    fun_2_i,
    output logic          valid_1,
    output logic [RW-1:0] rd_1,
    output logic          wr_1,
    output logic [DW-1:0] data_A_1,
    output logic [DW-1:0] data_B_1,
    output logic [DW-1:0] imm_1,
    output logic [4:0]    shamt_1,
    output logic [1:0]    mux_1,
    output logic [3:0]    fun_1,
    output logic          valid_2,
    output logic [RW-1:0] rd_2,
    output logic          wr_2,
    output logic [DW-1:0] data_A_2,
    output logic [DW-1:0] data_B_2,
    output logic [DW-1:0] imm_2,
    output logic [4:0]    shamt_2,
    output logic [1:0]    mux_2,
    output logic [3:0]    fun_2,
    output logic [CW-1:0] split_cnt,
    output logic [CW-1:0] issue_cnt
);

    typedef enum logic {PAIR = 1'b0, HOLD2 = 1'b1} state_t;
    state_t state;

    logic [RW-1:0] h_rd;
    logic          h_wr, h_ma, h_mb;
    logic [DW-1:0] h_data_A, h_data_B, h_imm;
    logic [4:0]    h_shamt;
    logic [1:0]    h_mux;
    logic [3:0]    h_fun;

    logic ma, mb, dep, accept;

    // Lane-1 source fields are never inspected; the dependency only looks one way.
    logic unused_lane1;
    assign unused_lane1 = ^{rs_1_i, rt_1_i, use_rs_1_i, use_rt_1_i};

    assign ma       = use_rs_2_i && (rs_2_i == rd_1_i);
    assign mb       = use_rt_2_i && (rt_2_i == rd_1_i);
    assign dep      = vld_1_i && vld_2_i && wr_1_i && (rd_1_i != '0) && (ma || mb);
    assign in_ready = (state == PAIR) && !ex_stall && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PAIR;
            valid_1  <= 1'b0;  rd_1 <= '0;  wr_1 <= 1'b0;
            data_A_1 <= '0;    data_B_1 <= '0;  imm_1 <= '0;
            shamt_1  <= '0;    mux_1 <= '0;  fun_1 <= '0;
            valid_2  <= 1'b0;  rd_2 <= '0;  wr_2 <= 1'b0;
            data_A_2 <= '0;    data_B_2 <= '0;  imm_2 <= '0;
            shamt_2  <= '0;    mux_2 <= '0;  fun_2 <= '0;
            h_rd     <= '0;    h_wr <= 1'b0;  h_ma <= 1'b0;  h_mb <= 1'b0;
            h_data_A <= '0;    h_data_B <= '0;  h_imm <= '0;
            h_shamt  <= '0;    h_mux <= '0;  h_fun <= '0;
        end else if (flush) begin
            valid_1 <= 1'b0;
            valid_2 <= 1'b0;
            state   <= PAIR;
        end else if (!ex_stall) begin
            case (state)
                PAIR: begin
                    if (in_valid) begin
                        valid_1  <= vld_1_i;     rd_1 <= rd_1_i;  wr_1 <= wr_1_i;
                        data_A_1 <= data_A_1_i;  data_B_1 <= data_B_1_i;
                        imm_1    <= imm_1_i;     shamt_1 <= shamt_1_i;
                        mux_1    <= mux_1_i;     fun_1 <= fun_1_i;
                        if (dep) begin
                            valid_2  <= 1'b0;
                            h_rd     <= rd_2_i;      h_wr <= wr_2_i;
                            h_ma     <= ma;          h_mb <= mb;
                            h_data_A <= data_A_2_i;  h_data_B <= data_B_2_i;
                            h_imm    <= imm_2_i;     h_shamt <= shamt_2_i;
                            h_mux    <= mux_2_i;     h_fun <= fun_2_i;
                            state    <= HOLD2;
                        end else begin
                            valid_2  <= vld_2_i;     rd_2 <= rd_2_i;  wr_2 <= wr_2_i;
                            data_A_2 <= data_A_2_i;  data_B_2 <= data_B_2_i;
                            imm_2    <= imm_2_i;     shamt_2 <= shamt_2_i;
                            mux_2    <= mux_2_i;     fun_2 <= fun_2_i;
                        end
                    end else begin
                        valid_1 <= 1'b0;
                        valid_2 <= 1'b0;
                    end
                end
                HOLD2: begin
                    // ex_alu_1 now carries the result of the lane-1 op issued last edge.
                    valid_1  <= 1'b0;
                    valid_2  <= 1'b1;
                    rd_2     <= h_rd;   wr_2 <= h_wr;
                    data_A_2 <= h_ma ? ex_alu_1 : h_data_A;
                    data_B_2 <= h_mb ? ex_alu_1 : h_data_B;
                    imm_2    <= h_imm;  shamt_2 <= h_shamt;
                    mux_2    <= h_mux;  fun_2 <= h_fun;
                    state    <= PAIR;
                end
                default: state <= PAIR;
            endcase
        end
    end

`ifdef ISSUE_PAIR_STATS_EN
    logic [1:0]  issue_inc;
    logic        split_inc;
    logic [CW:0] issue_sum, split_sum;

    always_comb begin
        issue_inc = 2'd0;
        split_inc = 1'b0;
        if (!flush && !ex_stall) begin
            if (state == HOLD2) begin
                issue_inc = 2'd1;
            end else if (in_valid) begin
                issue_inc = {1'b0, vld_1_i} + {1'b0, (vld_2_i && !dep)};
                split_inc = dep;
            end
        end
    end

    assign issue_sum = {1'b0, issue_cnt} + {{(CW - 1){1'b0}}, issue_inc};
    assign split_sum = {1'b0, split_cnt} + {{CW{1'b0}}, split_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt <= '0;
            split_cnt <= '0;
        end else begin
            issue_cnt <= issue_sum[CW] ? {CW{1'b1}} : issue_sum[CW-1:0];
            split_cnt <= split_sum[CW] ? {CW{1'b1}} : split_sum[CW-1:0];
        end
    end
`else
    assign issue_cnt = '0;
    assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_pair_reg.sv
// Directed bench for issue_pair_reg: pairing, RAW split/forward, stall, flush and async reset.
module tb_issue_pair_reg;
    localparam int DW = 32, RW = 5, CW = 16;

    logic clk = 1'b0, reset, in_valid, in_ready, flush, ex_stall;
    logic [DW-1:0] ex_alu_1;
    logic vld_1_i, wr_1_i, use_rs_1_i, use_rt_1_i, vld_2_i, wr_2_i, use_rs_2_i, use_rt_2_i;
    logic [RW-1:0] rs_1_i, rt_1_i, rd_1_i, rs_2_i, rt_2_i, rd_2_i;
    logic [DW-1:0] data_A_1_i, data_B_1_i, imm_1_i, data_A_2_i, data_B_2_i, imm_2_i;
    logic [4:0] shamt_1_i, shamt_2_i;
    logic [1:0] mux_1_i, mux_2_i;
    logic [3:0] fun_1_i, fun_2_i;
    logic valid_1, wr_1, valid_2, wr_2;
    logic [RW-1:0] rd_1, rd_2;
    logic [DW-1:0] data_A_1, data_B_1, imm_1, data_A_2, data_B_2, imm_2;
    logic [4:0] shamt_1, shamt_2;
    logic [1:0] mux_1, mux_2;
    logic [3:0] fun_1, fun_2;
    logic [CW-1:0] split_cnt, issue_cnt;

    int checks = 0, errors = 0;
    int exp_split = 0, exp_issue = 0;

    always #5 clk = ~clk;

    issue_pair_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ex_stall(ex_stall), .ex_alu_1(ex_alu_1),
        .vld_1_i(vld_1_i), .rs_1_i(rs_1_i), .rt_1_i(rt_1_i), .rd_1_i(rd_1_i),
        .wr_1_i(wr_1_i), .use_rs_1_i(use_rs_1_i), .use_rt_1_i(use_rt_1_i),
        .data_A_1_i(data_A_1_i), .data_B_1_i(data_B_1_i), .imm_1_i(imm_1_i),
        .shamt_1_i(shamt_1_i), .mux_1_i(mux_1_i), .fun_1_i(fun_1_i),
        .vld_2_i(vld_2_i), .rs_2_i(rs_2_i), .rt_2_i(rt_2_i), .rd_2_i(rd_2_i),
        .wr_2_i(wr_2_i), .use_rs_2_i(use_rs_2_i), .use_rt_2_i(use_rt_2_i),
        .data_A_2_i(data_A_2_i), .data_B_2_i(data_B_2_i), .imm_2_i(imm_2_i),
        .shamt_2_i(shamt_2_i), .mux_2_i(mux_2_i), .fun_2_i(fun_2_i),
        .valid_1(valid_1), .rd_1(rd_1), .wr_1(wr_1), .data_A_1(data_A_1),
        .data_B_1(data_B_1), .imm_1(imm_1), .shamt_1(shamt_1), .mux_1(mux_1), .fun_1(fun_1),
        .valid_2(valid_2), .rd_2(rd_2), .wr_2(wr_2), .data_A_2(data_A_2),
        .data_B_2(data_B_2), .imm_2(imm_2), .shamt_2(shamt_2), .mux_2(mux_2), .fun_2(fun_2),
        .split_cnt(split_cnt), .issue_cnt(issue_cnt)
    );

    task automatic set_l1(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic wr, input logic urs,
                          input logic urt, input logic [31:0] a, input logic [31:0] b);
        vld_1_i = v; rs_1_i = rs; rt_1_i = rt; rd_1_i = rd; wr_1_i = wr;
        use_rs_1_i = urs; use_rt_1_i = urt; data_A_1_i = a; data_B_1_i = b;
    endtask

    task automatic set_l2(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic wr, input logic urs,
                          input logic urt, input logic [31:0] a, input logic [31:0] b);
        vld_2_i = v; rs_2_i = rs; rt_2_i = rt; rd_2_i = rd; wr_2_i = wr;
        use_rs_2_i = urs; use_rt_2_i = urt; data_A_2_i = a; data_B_2_i = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0; ex_alu_1 = '0;
        set_l1(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_l2(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        imm_1_i = 32'h1000; shamt_1_i = 5'd3; mux_1_i = 2'd1; fun_1_i = 4'd2;
        imm_2_i = 32'h2000; shamt_2_i = 5'd4; mux_2_i = 2'd2; fun_2_i = 4'd5;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++;
        if ({valid_1, valid_2, data_A_1, data_A_2, rd_1, fun_2} !== '0) begin
            errors++; $display("FAIL reset_outputs got v1=%0b v2=%0b A1=%0h A2=%0h want all 0",
                               valid_1, valid_2, data_A_1, data_A_2);
        end
        checks++;
        if ({split_cnt, issue_cnt} !== '0) begin
            errors++; $display("FAIL reset_counters got split=%0d issue=%0d want 0", split_cnt, issue_cnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %0b want 1", in_ready); end
    endtask

    task automatic test_independent();
        in_valid = 1'b1;
        set_l1(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'd5, 32'd7);
        set_l2(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 32'hA4, 32'hB5);
        tick();
        exp_issue += 2;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b111) begin
            errors++; $display("FAIL indep_valid got v1=%0b v2=%0b rdy=%0b want 1 1 1", valid_1, valid_2, in_ready);
        end
        checks++;
        if (data_A_1 !== 32'd5 || data_B_1 !== 32'd7 || data_A_2 !== 32'hA4 || data_B_2 !== 32'hB5) begin
            errors++; $display("FAIL indep_data got A1=%0h B1=%0h A2=%0h B2=%0h want 5 7 a4 b5",
                               data_A_1, data_B_1, data_A_2, data_B_2);
        end
        checks++;
        if (rd_1 !== 5'd3 || rd_2 !== 5'd6 || imm_2 !== 32'h2000 || shamt_1 !== 5'd3 ||
            mux_2 !== 2'd2 || fun_1 !== 4'd2 || fun_2 !== 4'd5 || wr_2 !== 1'b1) begin
            errors++; $display("FAIL indep_fields got rd1=%0d rd2=%0d imm2=%0h sh1=%0d mux2=%0d fun1=%0d fun2=%0d",
                               rd_1, rd_2, imm_2, shamt_1, mux_2, fun_1, fun_2);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({valid_1, valid_2} !== 2'b00) begin
            errors++; $display("FAIL idle_valid got v1=%0b v2=%0b want 0 0", valid_1, valid_2);
        end
    endtask

    task automatic test_raw_rs();
        in_valid = 1'b1;
        set_l1(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'd5, 32'd7);
        set_l2(1'b1, 5'd3, 5'd9, 5'd8, 1'b1, 1'b1, 1'b1, 32'h99, 32'h55);
        tick();
        exp_issue += 1; exp_split += 1;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b100) begin
            errors++; $display("FAIL raw_edge1 got v1=%0b v2=%0b rdy=%0b want 1 0 0", valid_1, valid_2, in_ready);
        end
        in_valid = 1'b0; ex_alu_1 = 32'd12;
        tick();
        exp_issue += 1;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b011) begin
            errors++; $display("FAIL raw_edge2 got v1=%0b v2=%0b rdy=%0b want 0 1 1", valid_1, valid_2, in_ready);
        end
        checks++;
        if (data_A_2 !== 32'd12 || data_B_2 !== 32'h55 || rd_2 !== 5'd8) begin
            errors++; $display("FAIL raw_forward got A2=%0h B2=%0h rd2=%0d want c 55 8", data_A_2, data_B_2, rd_2);
        end
`ifdef ISSUE_PAIR_STATS_EN
        checks++;
        if (split_cnt !== CW'(exp_split)) begin
            errors++; $display("FAIL raw_split_cnt got %0d want %0d", split_cnt, exp_split);
        end
`else
        checks++;
        if (split_cnt !== '0) begin errors++; $display("FAIL raw_split_cnt got %0d want 0", split_cnt); end
`endif
        ex_alu_1 = '0;
    endtask

    task automatic test_no_split_cases();
        in_valid = 1'b1;
        set_l1(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 32'h11, 32'h12);
        set_l2(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 32'h21, 32'h22);
        tick();
        exp_issue += 2;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b111 || data_A_2 !== 32'h21) begin
            errors++; $display("FAIL raw_r0 got v1=%0b v2=%0b rdy=%0b A2=%0h want 1 1 1 21",
                               valid_1, valid_2, in_ready, data_A_2);
        end
        set_l1(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 32'h31, 32'h32);
        set_l2(1'b0, 5'd4, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 32'h41, 32'h42);
        tick();
        exp_issue += 1;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b101) begin
            errors++; $display("FAIL lane2_invalid got v1=%0b v2=%0b rdy=%0b want 1 0 1", valid_1, valid_2, in_ready);
        end
        set_l2(1'b1, 5'd7, 5'd8, 5'd4, 1'b1, 1'b1, 1'b1, 32'h51, 32'h52);
        tick();
        exp_issue += 2;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b111 || rd_1 !== 5'd4 || rd_2 !== 5'd4) begin
            errors++; $display("FAIL same_rd got v1=%0b v2=%0b rdy=%0b rd1=%0d rd2=%0d want 1 1 1 4 4",
                               valid_1, valid_2, in_ready, rd_1, rd_2);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall_hold2();
        in_valid = 1'b1;
        set_l1(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 32'h71, 32'h72);
        set_l2(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 32'h22, 32'h11);
        tick();
        exp_issue += 1; exp_split += 1;
        in_valid = 1'b0; ex_stall = 1'b1; ex_alu_1 = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid_1, valid_2, in_ready} !== 3'b100 || data_A_1 !== 32'h71) begin
                errors++; $display("FAIL stall_freeze%0d got v1=%0b v2=%0b rdy=%0b A1=%0h want 1 0 0 71",
                                   i, valid_1, valid_2, in_ready, data_A_1);
            end
        end
        ex_stall = 1'b0;
        tick();
        exp_issue += 1;
        checks++;
        if ({valid_1, valid_2} !== 2'b01 || data_B_2 !== 32'h40 || data_A_2 !== 32'h22) begin
            errors++; $display("FAIL stall_release got v1=%0b v2=%0b A2=%0h B2=%0h want 0 1 22 40",
                               valid_1, valid_2, data_A_2, data_B_2);
        end
        ex_alu_1 = '0;
    endtask

    task automatic test_flush_hold2();
        in_valid = 1'b1;
        set_l1(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 32'h81, 32'h82);
        set_l2(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 32'h91, 32'h92);
        tick();
        exp_issue += 1; exp_split += 1;
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b001) begin
            errors++; $display("FAIL flush got v1=%0b v2=%0b rdy=%0b want 0 0 1", valid_1, valid_2, in_ready);
        end
        tick();
        checks++;
        if (valid_2 !== 1'b0) begin errors++; $display("FAIL flush_drop got v2=%0b want 0", valid_2); end
`ifdef ISSUE_PAIR_STATS_EN
        checks++;
        if (issue_cnt !== CW'(exp_issue) || split_cnt !== CW'(exp_split)) begin
            errors++; $display("FAIL stats got issue=%0d split=%0d want %0d %0d",
                               issue_cnt, split_cnt, exp_issue, exp_split);
        end
`endif
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        set_l1(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'hC1, 32'hC2);
        set_l2(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 32'hD1, 32'hD2);
        tick();
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({valid_1, valid_2, in_ready} !== 3'b000 || data_A_1 !== '0 || rd_1 !== '0) begin
            errors++; $display("FAIL async_reset got v1=%0b v2=%0b rdy=%0b A1=%0h want 0 0 0 0",
                               valid_1, valid_2, in_ready, data_A_1);
        end
        checks++;
        if ({split_cnt, issue_cnt} !== '0) begin
            errors++; $display("FAIL async_reset_cnt got split=%0d issue=%0d want 0", split_cnt, issue_cnt);
        end
        #1 reset = 1'b0;
        in_valid = 1'b1;
        set_l1(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'hE1, 32'hE2);
        set_l2(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 32'hF1, 32'hF2);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({valid_1, valid_2} !== 2'b11 || data_A_1 !== 32'hE1 || data_A_2 !== 32'hF1) begin
            errors++; $display("FAIL post_reset_issue got v1=%0b v2=%0b A1=%0h A2=%0h want 1 1 e1 f1",
                               valid_1, valid_2, data_A_1, data_A_2);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_rs();
        test_no_split_cases();
        test_stall_hold2();
        test_flush_hold2();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_pair_reg.md
Name: issue_pair_reg

Overview:
- Dual-lane issue register directly upstream of the two-ALU execute stage.
- Takes a decoded instruction pair from decode and drives registered operands and controls to ALU lanes 1 and 2.
- Detects a lane-2 read-after-write dependency on lane-1's destination. On a hit it splits the bundle over two cycles and forwards lane-1's ALU result into lane-2's operands.
- Supports downstream stall and pipeline flush.

Parameters:
DW, 32, operand/result data width
RW, 5, register-address width
CW, 16, statistics counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  decode presents a bundle
in_ready  out  1  bundle accepted on clk when in_valid && in_ready
flush  in  1  discard held and issued instructions
ex_stall  in  1  downstream cannot accept; hold all outputs
ex_alu_1  in  DW  lane-1 ALU result from execute (combinational, same cycle)
vld_k_i  in  1  lane k (k=1,2) slot holds a real instruction
rs_k_i, rt_k_i, rd_k_i  in  RW  lane k source/destination register addresses
wr_k_i  in  1  lane k writes rd
use_rs_k_i, use_rt_k_i  in  1  lane k reads rs / rt
data_A_k_i, data_B_k_i, imm_k_i  in  DW  lane k regfile operands, sign-extended immediate
shamt_k_i  in  5  lane k shift amount
mux_k_i  in  2  lane k B select (0 reg, 1 imm, 2 shamt)
fun_k_i  in  4  lane k ALU function
valid_k, rd_k, wr_k, data_A_k, data_B_k, imm_k, shamt_k, mux_k, fun_k  out  as inputs  registered lane k issue outputs
split_cnt, issue_cnt  out  CW  statistics (see Optional Feature)

Behaviour:
- Reset: state=PAIR; every registered output=0, including valid_1/valid_2; counters=0. in_ready=0 while reset is high.
- Combinational ready: in_ready = (state==PAIR) && !ex_stall && !reset.
- Dependency: dep = vld_1_i && vld_2_i && wr_1_i && rd_1_i!=0 && ((use_rs_2_i && rs_2_i==rd_1_i) || (use_rt_2_i && rt_2_i==rd_1_i)).
- Latency: one clock from acceptance to issue outputs. Outputs change only on clk edges.
- Priority per edge: flush > ex_stall > normal.
- flush: valid_1=valid_2=0, held lane-2 discarded, state=PAIR. Data outputs are don't-care but held.
- ex_stall (no flush): all outputs and state hold. No acceptance.
- State PAIR, accept with !dep: both lanes registered; valid_k=vld_k_i; stay PAIR.
- State PAIR, accept with dep:
  - Lane 1 registered, valid_1=1, valid_2=0.
  - Lane-2 fields and match bits (mA = rs_2_i==rd_1_i && use_rs_2_i, mB = rt_2_i==rd_1_i && use_rt_2_i) captured in an internal hold register.
  - Next state HOLD2.
- State PAIR, no acceptance (in_valid=0): valid_1=valid_2=0.
- State HOLD2 (no stall/flush):
  - Issue held lane 2 in lane-2 slot with valid_1=0, valid_2=1.
  - data_A_2 = mA ? ex_alu_1 : held data_A; data_B_2 = mB ? ex_alu_1 : held data_B.
  - ex_alu_1 at this edge is the lane-1 result of the instruction issued on the previous edge.
  - Next state PAIR.
- A stall in HOLD2 keeps HOLD2 and keeps the lane-1 outputs unchanged, so ex_alu_1 remains valid when the stall releases.
- Bundle with vld_2_i=0 or vld_1_i=0 never splits. Both lanes writing the same rd is not a hazard here; the later stage resolves it in favour of lane 2.
- Reset asserted mid-HOLD2 drops the held instruction.

Optional Feature:
- Macro: ISSUE_PAIR_STATS_EN.
- Defined:
  - issue_cnt += number of valid lanes issued per non-stalled edge.
  - split_cnt += 1 per PAIR→HOLD2 transition.
  - Both counters saturate at 2^CW-1 and clear on reset. flush does not clear them.
- Undefined: no counter logic; split_cnt and issue_cnt tied to 0.

Test Plan:
- Independent pair: lane1 add r3←r1,r2 (A=5,B=7), lane2 sub r6←r4,r5 → next edge valid_1=valid_2=1, data_A_1=5, data_A_2=A_2 input, in_ready stays 1.
- RAW on rs: lane1 rd=3, lane2 rs=3 (data_A_2_i=0x99), ex_alu_1=12 on following cycle:
  - Edge 1: valid_1=1, valid_2=0, in_ready=0.
  - Edge 2: valid_2=1, valid_1=0, data_A_2=12.
  - split_cnt=1 when the feature is enabled.
- RAW to r0 (rd_1_i=0, rs_2_i=0): no split, both valid in one cycle.
- ex_stall held 3 cycles in HOLD2 with ex_alu_1=0x40 → outputs frozen. On release, data_B_2=0x40 when mB is set.
- flush during HOLD2 → next edge valid_1=valid_2=0, state PAIR, in_ready=1; held lane 2 never issues.
- reset asserted asynchronously mid-cycle with valid outputs → all outputs 0 immediately, in_ready=0. After release, the first bundle issues normally.
